// File: rtl/input_conditioner_pkg.sv
// Shared constants, debounce state type and counter sizing helper for the
// multi-channel input conditioner.
package input_conditioner_pkg;

   localparam int DEFAULT_SYNC_STAGES     = 3;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   // Debounce state is implied by comparing the synchronized sample with level.
   typedef enum logic {
      DB_STABLE  = 1'b0,
      DB_PENDING = 1'b1
   } db_state_e;

   // Counter width able to hold 0 .. cycles.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One input channel: synchronizer chain, consecutive-sample debouncer,
// registered rise/fall pulses and a sticky event flag with clear.
module input_conditioner_channel
   import input_conditioner_pkg::*;
#(
   parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in,
   input  logic clear,
   output logic level,
   output logic rise,
   output logic fall,
   output logic event_flag
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_pipe;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nxt;
   logic                   r_level;
   logic                   w_level_nxt;
   logic                   r_rise;
   logic                   w_rise_nxt;
   logic                   r_fall;
   logic                   w_fall_nxt;
   logic                   r_flag;
   logic                   w_flag_nxt;
   logic                   w_s;
   db_state_e              w_state;

   assign w_s = r_pipe[SYNC_STAGES-1];

   // Synchronizer shift register; every stage resets to the channel's reset level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pipe <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         r_pipe <= {r_pipe[SYNC_STAGES-2:0], in};
      end
   end

   // Debounce next-state: count consecutive differing samples, flip level on the last one.
   always_comb begin
      w_state     = (w_s == r_level) ? DB_STABLE : DB_PENDING;
      w_cnt_nxt   = CNT_ZERO;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (w_state)
         DB_STABLE: begin
            w_cnt_nxt = CNT_ZERO;
         end
         DB_PENDING: begin
            if (r_cnt == CNT_LAST) begin
               w_level_nxt = w_s;
               w_rise_nxt  = w_s;
               w_fall_nxt  = ~w_s;
               w_cnt_nxt   = CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_cnt_nxt = CNT_ZERO;
         end
      endcase
      // A new edge outranks a simultaneous clear so no event is lost.
      if (w_rise_nxt || w_fall_nxt) begin
         w_flag_nxt = 1'b1;
      end else if (clear) begin
         w_flag_nxt = 1'b0;
      end else begin
         w_flag_nxt = r_flag;
      end
   end

   // Debounce counter, level, pulses and event flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= CNT_ZERO;
         r_level <= RESET_LEVEL;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_flag  <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_flag  <= w_flag_nxt;
      end
   end

   assign level      = r_level;
   assign rise       = r_rise;
   assign fall       = r_fall;
   assign event_flag = r_flag;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: independent per-channel conditioners
// between asynchronous pads and control logic.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int                  CHANNELS        = 4,
   parameter int                  SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int                  DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] in,
   input  logic [CHANNELS-1:0] clear,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] event_flag
);

   // Reject illegal configurations at elaboration.
   if (CHANNELS < 1) begin : g_bad_channels
      $fatal(1, "input_conditioner: CHANNELS must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "input_conditioner: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $fatal(1, "input_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      input_conditioner_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RESET_VALUE[gi])
      ) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .in         (in[gi]),
         .clear      (clear[gi]),
         .level      (level[gi]),
         .rise       (rise[gi]),
         .fall       (fall[gi]),
         .event_flag (event_flag[gi])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: four conditioner instances (two default, two swept
// configurations) compared every cycle against a sample-history reference
// model, plus directed latency, glitch, flag and reset sequences.
module tb_input_conditioner;

   localparam int NI = 4;
   localparam int S_OF [NI] = '{3, 3, 2, 5};
   localparam int D_OF [NI] = '{4, 4, 1, 16};
   localparam logic [3:0] RV_OF [NI] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000};

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] in_v  [NI];
   logic [3:0] clr_v [NI];
   logic [3:0] lvl   [NI];
   logic [3:0] rse   [NI];
   logic [3:0] fll   [NI];
   logic [3:0] flg   [NI];

   // reference model state
   logic [3:0] hq    [NI][$];
   logic [3:0] m_lvl [NI];
   logic [3:0] m_rse [NI];
   logic [3:0] m_fll [NI];
   logic [3:0] m_flg [NI];

   int n_vec = 0;
   int n_mis = 0;

   typedef struct {
      int   inst;
      int   ch;
      logic val;
      int   lat;
   } lat_vec_t;
   lat_vec_t tbl [7];

   always #5 clk = ~clk;

   input_conditioner #(.RESET_VALUE(4'b0101)) u_a (
      .clk(clk), .reset_n(reset_n), .in(in_v[0]), .clear(clr_v[0]),
      .level(lvl[0]), .rise(rse[0]), .fall(fll[0]), .event_flag(flg[0]));
   input_conditioner u_b (
      .clk(clk), .reset_n(reset_n), .in(in_v[1]), .clear(clr_v[1]),
      .level(lvl[1]), .rise(rse[1]), .fall(fll[1]), .event_flag(flg[1]));
   input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_c (
      .clk(clk), .reset_n(reset_n), .in(in_v[2]), .clear(clr_v[2]),
      .level(lvl[2]), .rise(rse[2]), .fall(fll[2]), .event_flag(flg[2]));
   input_conditioner #(.SYNC_STAGES(5), .DEBOUNCE_CYCLES(16)) u_d (
      .clk(clk), .reset_n(reset_n), .in(in_v[3]), .clear(clr_v[3]),
      .level(lvl[3]), .rise(rse[3]), .fall(fll[3]), .event_flag(flg[3]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // History holds the raw input seen at each edge; prefilled with the reset level.
   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         hq[i].delete();
         for (int k = 0; k < S_OF[i] + D_OF[i] + 1; k++) hq[i].push_back(RV_OF[i]);
         m_lvl[i] = RV_OF[i];
         m_rse[i] = 4'b0000;
         m_fll[i] = 4'b0000;
         m_flg[i] = 4'b0000;
      end
   endtask

   // The synchronized sample used at an edge is the input captured SYNC_STAGES edges
   // earlier; level flips when the last DEBOUNCE_CYCLES such samples all differ from it.
   task automatic model_step();
      for (int i = 0; i < NI; i++) begin
         logic [3:0] old_l;
         logic       run;
         int         top;
         hq[i].push_back(in_v[i]);
         top   = hq[i].size() - 1 - S_OF[i];
         old_l = m_lvl[i];
         for (int c = 0; c < 4; c++) begin
            run = 1'b1;
            for (int j = 0; j < D_OF[i]; j++) begin
               if (hq[i][top - j][c] == old_l[c]) run = 1'b0;
            end
            m_rse[i][c] = run & ~old_l[c];
            m_fll[i][c] = run & old_l[c];
            if (run) begin
               m_lvl[i][c] = ~old_l[c];
               m_flg[i][c] = 1'b1;
            end else if (clr_v[i][c]) begin
               m_flg[i][c] = 1'b0;
            end
         end
         while (hq[i].size() > S_OF[i] + D_OF[i] + 1) void'(hq[i].pop_front());
      end
   endtask

   // One clock: advance model at the edge, compare just after it, return at negedge.
   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      else model_reset();
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("model_u%0d", i),
             {16'h0000, lvl[i], rse[i], fll[i], flg[i]},
             {16'h0000, m_lvl[i], m_rse[i], m_fll[i], m_flg[i]});
      end
      @(negedge clk);
   endtask

   initial begin
      int nr;
      int nf;
      tbl[0] = '{1, 0, 1'b1, 6};
      tbl[1] = '{1, 0, 1'b0, 6};
      tbl[2] = '{2, 1, 1'b1, 2};
      tbl[3] = '{2, 1, 1'b0, 2};
      tbl[4] = '{3, 2, 1'b1, 20};
      tbl[5] = '{3, 2, 1'b0, 20};
      tbl[6] = '{0, 3, 1'b1, 6};

      for (int i = 0; i < NI; i++) begin
         in_v[i]  = RV_OF[i];
         clr_v[i] = 4'b0000;
      end
      model_reset();
      for (int k = 0; k < 3; k++) tick();
      chk("reset_level_a", {28'h0, lvl[0]}, 32'h5);
      chk("reset_flags_a", {20'h0, rse[0], fll[0], flg[0]}, 32'h0);
      reset_n = 1'b1;

      // reset mid-operation restores the per-channel reset value immediately
      in_v[0] = 4'b1010;
      for (int k = 0; k < 10; k++) tick();
      chk("pre_reset_level_a", {28'h0, lvl[0]}, 32'hA);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_level_a", {28'h0, lvl[0]}, 32'h5);
      chk("async_reset_flags_a", {20'h0, rse[0], fll[0], flg[0]}, 32'h0);
      tick();
      in_v[0] = 4'b0101;
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("no_pulse_after_release", {24'h0, rse[0], fll[0]}, 32'h0);
      end

      // latency table
      for (int r = 0; r < 7; r++) begin
         int   n;
         int   ii;
         int   cc;
         logic seen;
         ii = tbl[r].inst;
         cc = tbl[r].ch;
         in_v[ii][cc] = tbl[r].val;
         seen = 1'b0;
         n = 0;
         while (!seen && n < tbl[r].lat + 6) begin
            tick();
            n++;
            if (lvl[ii][cc] == tbl[r].val) seen = 1'b1;
         end
         chk($sformatf("latency_row%0d", r), seen ? 32'(n - 1) : 32'hFFFF_FFFF, 32'(tbl[r].lat));
         chk($sformatf("rise_row%0d", r), {31'h0, rse[ii][cc]}, {31'h0, tbl[r].val});
         chk($sformatf("fall_row%0d", r), {31'h0, fll[ii][cc]}, {31'h0, ~tbl[r].val});
         tick();
         chk($sformatf("pulse_drop_row%0d", r), {30'h0, rse[ii][cc], fll[ii][cc]}, 32'h0);
         chk($sformatf("flag_row%0d", r), {31'h0, flg[ii][cc]}, 32'h1);
      end

      // glitch rejection on u_b channel 1
      nr = 0;
      in_v[1][1] = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      in_v[1][1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         nr += int'(rse[1][1]);
      end
      chk("glitch3_rise", 32'(nr), 32'h0);
      chk("glitch3_level_flag", {30'h0, lvl[1][1], flg[1][1]}, 32'h0);
      nr = 0;
      nf = 0;
      in_v[1][1] = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      in_v[1][1] = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         nr += int'(rse[1][1]);
         nf += int'(fll[1][1]);
      end
      chk("pulse4_rises", 32'(nr), 32'h1);
      chk("pulse4_falls", 32'(nf), 32'h1);
      chk("pulse4_level", {31'h0, lvl[1][1]}, 32'h0);

      // event flag clear and set/clear collision on u_b channel 2
      clr_v[1][2] = 1'b1;
      tick();
      clr_v[1][2] = 1'b0;
      chk("clear_when_zero", {31'h0, flg[1][2]}, 32'h0);
      in_v[1][2] = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("flag_set_rise", {31'h0, flg[1][2]}, 32'h1);
      clr_v[1][2] = 1'b1;
      tick();
      clr_v[1][2] = 1'b0;
      chk("flag_cleared", {31'h0, flg[1][2]}, 32'h0);
      in_v[1][2] = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk("flag_set_fall", {31'h0, flg[1][2]}, 32'h1);
      clr_v[1][2] = 1'b1;
      tick();
      clr_v[1][2] = 1'b0;
      in_v[1][2] = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      clr_v[1][2] = 1'b1;
      tick();
      clr_v[1][2] = 1'b0;
      chk("collision_rise", {31'h0, rse[1][2]}, 32'h1);
      chk("collision_flag", {31'h0, flg[1][2]}, 32'h1);
      tick();
      chk("collision_flag_hold", {31'h0, flg[1][2]}, 32'h1);

      // reset while u_b channel 3 is mid-debounce (counter at 2)
      in_v[1][3] = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("mid_debounce_reset_level", {31'h0, lvl[1][3]}, 32'h0);
      tick();
      in_v[1][3] = 1'b0;
      for (int i = 0; i < NI; i++) in_v[i] = RV_OF[i];
      reset_n = 1'b1;
      nr = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         nr += int'(rse[1][3]);
      end
      chk("aborted_no_rise", 32'(nr), 32'h0);
      chk("aborted_no_flag", {31'h0, flg[1][3]}, 32'h0);

      // randomized bouncing inputs and clears on all instances
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 4; c++) begin
               if ($urandom_range(0, (i == 3) ? 40 : 6) == 0) in_v[i][c] = ~in_v[i][c];
               clr_v[i][c] = ($urandom_range(0, 7) == 0);
            end
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
